// File: rtl/debounce_pkg.sv
// Shared constants and edge-type enum for the multi-channel debouncer.
package debounce_pkg;
  localparam int DEF_STABLE_CNT = 100;
  localparam int DEF_HOLD_CNT   = 50000000;
  localparam int SYNC_STAGES    = 2;

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } edge_t;
endpackage

// File: rtl/multi_debouncer_if.sv
// Channel bundle between the board inputs and the debouncer; long_press only
// exists when DEBOUNCE_HOLD_EN is defined.
interface multi_debouncer_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] data_in;
  logic [N_CH-1:0] data_out;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
`ifdef DEBOUNCE_HOLD_EN
  logic [N_CH-1:0] long_press;
`endif

  modport master (
    output data_in,
    input  data_out,
    input  rise,
    input  fall
`ifdef DEBOUNCE_HOLD_EN
    ,input long_press
`endif
  );

  modport slave (
    input  data_in,
    output data_out,
    output rise,
    output fall
`ifdef DEBOUNCE_HOLD_EN
    ,output long_press
`endif
  );
endinterface

// File: rtl/debounce_ch.sv
// One debouncer channel: synchroniser, symmetric stability counter, edge
// strobes and (with DEBOUNCE_HOLD_EN) a saturating long-press counter.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = DEF_STABLE_CNT
`ifdef DEBOUNCE_HOLD_EN
  ,parameter int HOLD_CNT = DEF_HOLD_CNT
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o
`ifdef DEBOUNCE_HOLD_EN
  ,output logic long_press_o
`endif
);
  localparam int CNT_W = $clog2(STABLE_CNT + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  edge_t                  edge_q, edge_d;
  logic                   filt;

  assign filt   = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], din_i};

  // Any sample equal to the current output throws away the partial count.
  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    edge_d = EDGE_NONE;
    if (filt != dout_q) begin
      if (cnt_q == CNT_W'(STABLE_CNT - 1)) begin
        dout_d = filt;
        edge_d = filt ? EDGE_RISE : EDGE_FALL;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      dout_q <= 1'b0;
      edge_q <= EDGE_NONE;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      edge_q <= edge_d;
    end
  end

  assign dout_o = dout_q;
  assign rise_o = (edge_q == EDGE_RISE);
  assign fall_o = (edge_q == EDGE_FALL);

`ifdef DEBOUNCE_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_CNT + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (!dout_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_W'(HOLD_CNT)) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign long_press_o = (hold_q == HOLD_W'(HOLD_CNT));
`endif
endmodule

// File: rtl/multi_debouncer.sv
// N-channel symmetric debouncer; define DEBOUNCE_HOLD_EN to add the
// per-channel long_press output.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int STABLE_CNT = DEF_STABLE_CNT
`ifdef DEBOUNCE_HOLD_EN
  ,parameter int HOLD_CNT  = DEF_HOLD_CNT
`endif
) (
  input logic              clk,
  input logic              rst,
  multi_debouncer_if.slave bus
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_CNT (STABLE_CNT)
`ifdef DEBOUNCE_HOLD_EN
      ,.HOLD_CNT  (HOLD_CNT)
`endif
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .din_i        (bus.data_in[i]),
      .dout_o       (bus.data_out[i]),
      .rise_o       (bus.rise[i]),
      .fall_o       (bus.fall[i])
`ifdef DEBOUNCE_HOLD_EN
      ,.long_press_o(bus.long_press[i])
`endif
    );
  end
endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed scenarios with literal expectations plus
// randomized traffic against a window-based behavioural model.
module tb_multi_debouncer;
  localparam int N    = 4;
  localparam int S    = 4;
  localparam int H    = 10;
  localparam int MAXC = 6000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_debouncer_if #(.N_CH(N)) bus ();

  multi_debouncer #(
    .N_CH       (N),
    .STABLE_CNT (S)
`ifdef DEBOUNCE_HOLD_EN
    ,.HOLD_CNT  (H)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: output flips once the last S filter samples (input delayed two
  // edges, zero right after reset) all disagree with it.
  int              k = 0;
  int              last_rst = -1000;
  logic [N-1:0]    in_hist   [0:MAXC-1];
  logic [N-1:0]    filt_hist [0:MAXC-1];
  logic [N-1:0]    m_out  = '0;
  logic [N-1:0]    m_rise = '0;
  logic [N-1:0]    m_fall = '0;
  logic [N-1:0]    m_long = '0;
  int              t_rise [N];

  always @(posedge clk) begin
    logic [N-1:0] prev;
    bit           all;
    in_hist[k] = bus.data_in;
    if (rst) begin
      last_rst     = k;
      filt_hist[k] = '0;
      m_out        = '0;
      m_rise       = '0;
      m_fall       = '0;
      m_long       = '0;
    end else begin
      filt_hist[k] = (k - 2 > last_rst) ? in_hist[k-2] : '0;
      prev   = m_out;
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < N; c++) begin
        m_long[c] = prev[c] && (k - t_rise[c] >= H);
        all = 1'b1;
        for (int j = 0; j < S; j++)
          if (k - j <= last_rst || filt_hist[k-j][c] == prev[c]) all = 1'b0;
        if (all) begin
          m_out[c] = ~prev[c];
          if (prev[c]) m_fall[c] = 1'b1;
          else begin
            m_rise[c] = 1'b1;
            t_rise[c] = k;
          end
        end
      end
    end
    k++;
  end

  always @(negedge clk) begin
    n_cmp++;
    if ({bus.data_out, bus.rise, bus.fall} !== {m_out, m_rise, m_fall}) begin
      n_err++;
      $display("FAIL model_cmp edge %0d: out/rise/fall got %h/%h/%h required %h/%h/%h",
               k, bus.data_out, bus.rise, bus.fall, m_out, m_rise, m_fall);
    end
    n_cmp++;
    if ((bus.rise & bus.fall) !== '0) begin
      n_err++;
      $display("FAIL strobe_excl edge %0d: rise&fall got %h required 0", k, bus.rise & bus.fall);
    end
`ifdef DEBOUNCE_HOLD_EN
    n_cmp++;
    if (bus.long_press !== m_long) begin
      n_err++;
      $display("FAIL model_long edge %0d: got %h required %h", k, bus.long_press, m_long);
    end
`endif
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int c = 0; c < N; c++) t_rise[c] = 0;
    bus.data_in = 4'hF;
    rst = 1'b1;

    // Reset with inputs high, then the full 2+S latency to rise.
    cyc(3);
    chk("rst_out",  32'(bus.data_out), 0);
    chk("rst_rise", 32'(bus.rise), 0);
    chk("rst_fall", 32'(bus.fall), 0);
    rst = 1'b0;
    cyc(5);
    chk("t1_out_early", 32'(bus.data_out), 0);
    cyc(1);
    chk("t1_out",  32'(bus.data_out), 32'hF);
    chk("t1_rise", 32'(bus.rise), 32'hF);
    chk("t1_fall", 32'(bus.fall), 0);
    cyc(1);
    chk("t1_rise_once", 32'(bus.rise), 0);

    // Bouncing channel 0, then a clean hold.
    bus.data_in = 4'h0;
    cyc(8);
    chk("t2_cleared", 32'(bus.data_out), 0);
    for (int i = 0; i < 20; i++) begin
      bus.data_in[0] = (i % 2 == 0);
      cyc(1);
      chk("t2_bounce_out", 32'(bus.data_out[0]), 0);
      chk("t2_bounce_rise", 32'(bus.rise[0]), 0);
    end
    bus.data_in[0] = 1'b1;
    cyc(5);
    chk("t2_out_early", 32'(bus.data_out[0]), 0);
    cyc(1);
    chk("t2_out",  32'(bus.data_out[0]), 1);
    chk("t2_rise", 32'(bus.rise[0]), 1);
    cyc(1);
    chk("t2_rise_once", 32'(bus.rise[0]), 0);

    // Short release glitch on channel 1 is ignored; a held release is not.
    bus.data_in[1] = 1'b1;
    cyc(8);
    chk("t3_high", 32'(bus.data_out[1]), 1);
    bus.data_in[1] = 1'b0;
    cyc(3);
    bus.data_in[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("t3_glitch_fall", 32'(bus.fall[1]), 0);
      chk("t3_glitch_out", 32'(bus.data_out[1]), 1);
    end
    bus.data_in[1] = 1'b0;
    cyc(5);
    chk("t3_out_early", 32'(bus.data_out[1]), 1);
    cyc(1);
    chk("t3_fall", 32'(bus.fall[1]), 1);
    chk("t3_out",  32'(bus.data_out[1]), 0);
    cyc(1);
    chk("t3_fall_once", 32'(bus.fall[1]), 0);

    // Opposite steps on channels 2 and 3 in the same cycle.
    bus.data_in[3] = 1'b1;
    cyc(8);
    chk("t4_ch3_high", 32'(bus.data_out[3]), 1);
    bus.data_in[2] = 1'b1;
    bus.data_in[3] = 1'b0;
    cyc(5);
    chk("t4_rise_early", 32'(bus.rise), 0);
    cyc(1);
    chk("t4_rise", 32'(bus.rise), 32'h4);
    chk("t4_fall", 32'(bus.fall), 32'h8);
    chk("t4_out",  32'(bus.data_out), 32'h5);

    // Reset in the middle of a count on channel 0.
    bus.data_in = 4'h0;
    cyc(8);
    chk("t5_cleared", 32'(bus.data_out), 0);
    bus.data_in[0] = 1'b1;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    chk("t5_rst_out", 32'(bus.data_out), 0);
    rst = 1'b0;
    cyc(5);
    chk("t5_out_early", 32'(bus.data_out[0]), 0);
    cyc(1);
    chk("t5_out",  32'(bus.data_out[0]), 1);
    chk("t5_rise", 32'(bus.rise[0]), 1);

`ifdef DEBOUNCE_HOLD_EN
    cyc(9);
    chk("t6_long_early", 32'(bus.long_press[0]), 0);
    cyc(1);
    chk("t6_long", 32'(bus.long_press[0]), 1);
    bus.data_in[0] = 1'b0;
    cyc(6);
    chk("t6_fall", 32'(bus.fall[0]), 1);
    chk("t6_long_hold", 32'(bus.long_press[0]), 1);
    cyc(1);
    chk("t6_long_drop", 32'(bus.long_press[0]), 0);
`endif

    // Randomized traffic alternating bouncy and calm periods.
    for (int blk = 0; blk < 15; blk++) begin
      int flip_max;
      flip_max = ($urandom_range(0, 1) == 0) ? 1 : 11;
      for (int i = 0; i < 200; i++) begin
        rst = ($urandom_range(0, 299) == 0);
        for (int c = 0; c < N; c++)
          if ($urandom_range(0, flip_max) == 0) bus.data_in[c] = ~bus.data_in[c];
        cyc(1);
      end
    end
    rst = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
